instr_loader: RTL
=================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, instruction-memory word-address width.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  in  1  single-cycle pulse that begins a load session.
REQ-005 SHALL have port in_valid  in  1  instruction request valid.
REQ-006 SHALL have port in_ready  out  1  request accepted when in_valid & in_ready.
REQ-007 SHALL have port itype  in  3  0=R, 1=LW, 2=SW, 3=BEQ, 4=ADDI; 5-7 illegal.
REQ-008 SHALL have port funct3  in  3  used for R and ADDI only.
REQ-009 SHALL have port funct7b5  in  1  R-type bit 30.
REQ-010 SHALL have ports rd, rs1, rs2  in  5 each  register fields.
REQ-011 SHALL have port imm  in  13  signed immediate (13 bits for BEQ, low 12 bits otherwise).
REQ-012 SHALL have port last  in  1  qualifies the final request of a session.
REQ-013 SHALL have ports imem_we  out  1, imem_addr  out  ADDR_W, imem_wdata  out  32  memory write port.
REQ-014 SHALL have ports done  out  1, full  out  1, err  out  1  status flags.

Function
REQ-015 SHALL implement FSM IDLE, LOAD, DONE; IDLE->LOAD on start; LOAD->DONE after the write of a beat carrying last or the write to address 2^ADDR_W-1; DONE->LOAD on start.
REQ-016 start SHALL clear the address counter, done, full and err; start during LOAD SHALL restart at address 0, discarding no already-registered write.
REQ-017 in_ready SHALL be 1 only in LOAD and not in the cycle a terminating write is issued.
REQ-018 An accepted beat in cycle N SHALL produce imem_we=1 in cycle N+1 with imem_addr=counter and the encoded word; counter increments after each write (latency 1, throughput 1/cycle).
REQ-019 Encoding: R={0,funct7b5,00000,rs2,rs1,funct3,rd,0110011}; LW={imm[11:0],rs1,010,rd,0000011}; SW={imm[11:5],rs2,rs1,010,imm[4:0],0100011}; BEQ={imm[12],imm[10:5],rs2,rs1,000,imm[4:1],imm[11],1100011}; ADDI={imm[11:0],rs1,funct3,rd,0010011}.
REQ-020 Illegal itype SHALL write 32'h00000013 (NOP) and set sticky err.
REQ-021 full SHALL assert with the write to address 2^ADDR_W-1; done SHALL assert on entering DONE; both hold until start or reset.
REQ-022 imem_we SHALL be 0 whenever no beat was accepted in the prior cycle; imem_addr/imem_wdata hold their last values when imem_we=0.

Reset
REQ-023 reset SHALL force IDLE, counter=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, full=0, err=0, in_ready=0.
REQ-024 reset asserted mid-session SHALL cancel any pending write in the same cycle; no write follows deassertion without a new start.

Configuration
REQ-025 With IMM_RANGE_CHECK_EN defined, a non-BEQ imm whose bit 12 differs from bit 11, or a BEQ imm with imm[0]=1, SHALL write NOP and set err; without it, imm SHALL be truncated silently per REQ-019 and err SHALL only reflect illegal itype.

Structure
REQ-026 Opcode constants (0110011, 0000011, 0100011, 1100011, 0010011), itype codes and the NOP word SHALL live in the shared riscv_pkg package, shared with the main decoder.
REQ-027 Encoding SHALL be a combinational sub-module instr_encoder; instr_loader holds FSM, counter and output registers.

Verification
REQ-028 start, then addi x1,x0,5 -> next cycle imem_we=1, imem_addr=0, imem_wdata=0x00500093.
REQ-029 lw x2,8(x1); sw x2,4(x1); sub x3,x1,x2 back-to-back -> addrs 0,1,2 with 0x0080A103, 0x0020A223, 0x402081B3 on consecutive cycles.
REQ-030 beq x1,x2,-4 (imm=13'h1FFC) with last=1 -> 0xFE208EE3 written, then done=1, in_ready=0.
REQ-031 itype=6 -> 0x00000013 written, err=1 stays set until next start.
REQ-032 ADDR_W=2, four beats without last -> writes at 0..3, full=1, done=1, fifth in_valid not accepted.
REQ-033 reset asserted the cycle after acceptance -> imem_we=0 that cycle, all outputs at reset values, FSM in IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and loader state type,
// used by the instruction loader and the main decoder.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam logic [2:0] IT_R    = 3'd0;
    localparam logic [2:0] IT_LW   = 3'd1;
    localparam logic [2:0] IT_SW   = 3'd2;
    localparam logic [2:0] IT_BEQ  = 3'd3;
    localparam logic [2:0] IT_ADDI = 3'd4;

    localparam logic [31:0] NOP_WORD = 32'h00000013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } load_state_t;

endpackage

// File: rtl/instr_encoder.sv
// Combinational RV32I word encoder for the loader.
// Define IMM_RANGE_CHECK_EN to reject out-of-range immediates.
module instr_encoder
    import riscv_pkg::*;
(
    input  logic [2:0]  itype,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic [31:0] raw;
    logic        bad_type;
    logic        bad_imm;

    always_comb begin
        raw      = NOP_WORD;
        bad_type = 1'b0;
        case (itype)
            IT_R:    raw = {1'b0, funct7b5, 5'b00000, rs2, rs1,
                            funct3, rd, OP_R};
            IT_LW:   raw = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
            IT_SW:   raw = {imm[11:5], rs2, rs1, 3'b010, imm[4:0],
                            OP_STORE};
            IT_BEQ:  raw = {imm[12], imm[10:5], rs2, rs1, 3'b000,
                            imm[4:1], imm[11], OP_BRANCH};
            IT_ADDI: raw = {imm[11:0], rs1, funct3, rd, OP_IMM};
            default: bad_type = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Branch offsets must be even; others must fit in 12 signed bits.
    assign bad_imm = (itype == IT_BEQ) ? imm[0] : (imm[12] != imm[11]);
`else
    logic unused_imm_lsb;
    assign unused_imm_lsb = imm[0];
    assign bad_imm = 1'b0;
`endif

    assign illegal = bad_type | bad_imm;
    assign word    = illegal ? NOP_WORD : raw;

endmodule

// File: rtl/instr_loader.sv
// Streams encoded instructions into instruction memory, one per cycle.
// Optional IMM_RANGE_CHECK_EN enables immediate range checking.
module instr_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        itype,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [12:0]       imm,
    input  logic              last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W-1:0] MAX_ADDR = '1;

    load_state_t       state;
    load_state_t       state_nx;
    logic [ADDR_W-1:0] count;
    logic              term;
    logic              accept;
    logic              at_max;
    logic              terminal;
    logic [31:0]       word;
    logic              illegal;

    instr_encoder u_enc (
        .itype    (itype),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm      (imm),
        .word     (word),
        .illegal  (illegal)
    );

    // term marks the cycle the session's final write is on the port
    assign in_ready = (state == ST_LOAD) && !term && !start;
    assign accept   = in_valid && in_ready;
    assign at_max   = (count == MAX_ADDR);
    assign terminal = accept && (last || at_max);

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (start) state_nx = ST_LOAD;
            ST_LOAD: begin
                if (start)     state_nx = ST_LOAD;
                else if (term) state_nx = ST_DONE;
            end
            ST_DONE: if (start) state_nx = ST_LOAD;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            term       <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            done       <= 1'b0;
            full       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state   <= state_nx;
            imem_we <= accept;
            if (start) begin
                count <= '0;
                term  <= 1'b0;
                done  <= 1'b0;
                full  <= 1'b0;
                err   <= 1'b0;
            end else begin
                term <= terminal;
                if (accept) begin
                    count      <= count + 1'b1;
                    imem_addr  <= count;
                    imem_wdata <= word;
                    if (at_max)  full <= 1'b1;
                    if (illegal) err  <= 1'b1;
                end
                if (state == ST_LOAD && term) done <= 1'b1;
            end
        end
    end

endmodule
